// File: rtl/ysyx_24080014_axi_rd_arbiter.sv
// Two-master (IFU/LSU) AXI4-Lite read arbiter in front of the shared SRAM read port.
// Optional ARB_RR_EN: round-robin between simultaneous requesters instead of LSU-first.
//
//   state | meaning
//   IDLE  | no owner; pick a winner from pending arvalids
//   ADDR  | owner's AR forwarded to the slave
//   DATA  | owner's R channel connected to the slave
module ysyx_24080014_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,

    input  logic              ifu_arvalid,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_arready,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    input  logic              ifu_rready,

    input  logic              lsu_arvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    output logic              lsu_arready,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    input  logic              lsu_rready,

    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,

    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       last_owner_q, last_owner_d;   // 1 = LSU owned the last completed transaction
    logic       pick_lsu;
    logic       ar_fire;
    logic       r_fire;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
        end
    end

`ifdef ARB_RR_EN
    always_comb begin
        if (ifu_arvalid && lsu_arvalid) begin
            pick_lsu = ~last_owner_q;
        end else begin
            pick_lsu = lsu_arvalid;
        end
    end
`else
    always_comb begin
        pick_lsu = lsu_arvalid;
    end
`endif

    assign ar_fire = (state_q == ADDR) && s_arvalid && s_arready;
    assign r_fire  = (state_q == DATA) && s_rvalid && s_rready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    grant_d = pick_lsu ? 2'b10 : 2'b01;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ar_fire) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_fire) begin
                    last_owner_d = grant_q[1];
                    grant_d      = 2'b00;
                    state_d      = IDLE;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // Everything below is steered by the registered grant, so no arvalid reaches a ready.
    always_comb begin
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_rready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        case (state_q)
            ADDR: begin
                if (grant_q[1]) begin
                    s_arvalid   = lsu_arvalid;
                    s_araddr    = lsu_araddr;
                    lsu_arready = s_arready;
                end else if (grant_q[0]) begin
                    s_arvalid   = ifu_arvalid;
                    s_araddr    = ifu_araddr;
                    ifu_arready = s_arready;
                end
            end
            DATA: begin
                if (grant_q[1]) begin
                    lsu_rvalid = s_rvalid;
                    lsu_rdata  = s_rdata;
                    lsu_rresp  = s_rresp;
                    s_rready   = lsu_rready;
                end else if (grant_q[0]) begin
                    ifu_rvalid = s_rvalid;
                    ifu_rdata  = s_rdata;
                    ifu_rresp  = s_rresp;
                    s_rready   = ifu_rready;
                end
            end
            default: ;
        endcase
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_ysyx_24080014_axi_rd_arbiter.sv
// Directed bench for ysyx_24080014_axi_rd_arbiter; expectations follow ARB_RR_EN when defined.
module tb_ysyx_24080014_axi_rd_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic [1:0]  grant;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 ACLK = ~ACLK;

    ysyx_24080014_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .ifu_arvalid (ifu_arvalid),
        .ifu_araddr  (ifu_araddr),
        .ifu_arready (ifu_arready),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .ifu_rready  (ifu_rready),
        .lsu_arvalid (lsu_arvalid),
        .lsu_araddr  (lsu_araddr),
        .lsu_arready (lsu_arready),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rdata   (lsu_rdata),
        .lsu_rresp   (lsu_rresp),
        .lsu_rready  (lsu_rready),
        .s_arvalid   (s_arvalid),
        .s_araddr    (s_araddr),
        .s_arready   (s_arready),
        .s_rvalid    (s_rvalid),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .s_rready    (s_rready),
        .grant       (grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered on the falling edge where the DUT sits in ADDR for this owner.
    task automatic serve(input bit own_lsu, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int stall);
        logic [1:0] exp_g;
        exp_g = own_lsu ? 2'b10 : 2'b01;
        s_rvalid = 1'b1;
        s_rdata  = 32'hBAD0_BAD0;
        s_rresp  = 2'b11;
        if (own_lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
        #1;
        chk("addr_grant", grant, exp_g);
        chk("addr_s_arvalid", s_arvalid, 1'b1);
        chk("addr_s_araddr", s_araddr, addr);
        chk("addr_own_arready", own_lsu ? lsu_arready : ifu_arready, 1'b1);
        chk("addr_oth_arready", own_lsu ? ifu_arready : lsu_arready, 1'b0);
        chk("addr_rvalid_blocked", own_lsu ? lsu_rvalid : ifu_rvalid, 1'b0);
        chk("addr_rdata_blocked", own_lsu ? lsu_rdata : ifu_rdata, 32'h0);
        chk("addr_s_rready", s_rready, 1'b0);

        @(negedge ACLK);
        if (own_lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rresp  = resp;
        if (own_lsu) lsu_rready = (stall == 0); else ifu_rready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("stall_s_rready", s_rready, 1'b0);
            chk("stall_rvalid", own_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
            chk("stall_rdata", own_lsu ? lsu_rdata : ifu_rdata, data);
            chk("stall_grant", grant, exp_g);
            @(negedge ACLK);
        end
        if (own_lsu) lsu_rready = 1'b1; else ifu_rready = 1'b1;
        #1;
        chk("data_s_arvalid", s_arvalid, 1'b0);
        chk("data_rvalid", own_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
        chk("data_rdata", own_lsu ? lsu_rdata : ifu_rdata, data);
        chk("data_rresp", own_lsu ? lsu_rresp : ifu_rresp, resp);
        chk("data_s_rready", s_rready, 1'b1);
        chk("data_own_arready", own_lsu ? lsu_arready : ifu_arready, 1'b0);
        chk("data_oth_arready", own_lsu ? ifu_arready : lsu_arready, 1'b0);
        chk("data_oth_rvalid", own_lsu ? ifu_rvalid : lsu_rvalid, 1'b0);
        chk("data_oth_rdata", own_lsu ? ifu_rdata : lsu_rdata, 32'h0);
        chk("data_oth_rresp", own_lsu ? ifu_rresp : lsu_rresp, 2'b00);

        @(negedge ACLK);
        s_rvalid   = 1'b0;
        s_rdata    = 32'h0;
        s_rresp    = 2'b00;
        ifu_rready = 1'b0;
        lsu_rready = 1'b0;
        #1;
        chk("done_grant", grant, 2'b00);
        chk("done_s_arvalid", s_arvalid, 1'b0);
    endtask

    initial begin
        bit exp_lsu;
        ARESET      = 1'b1;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h1111_1111;
        ifu_rready  = 1'b1;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h2222_2222;
        lsu_rready  = 1'b1;
        s_arready   = 1'b1;
        s_rvalid    = 1'b1;
        s_rdata     = 32'hFFFF_FFFF;
        s_rresp     = 2'b11;

        // reset holds everything quiet even with all inputs active
        repeat (2) @(negedge ACLK);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_s_araddr", s_araddr, 32'h0);
        chk("rst_s_rready", s_rready, 1'b0);
        chk("rst_ifu_arready", ifu_arready, 1'b0);
        chk("rst_lsu_arready", lsu_arready, 1'b0);
        chk("rst_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("rst_lsu_rvalid", lsu_rvalid, 1'b0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk("rst_lsu_rresp", lsu_rresp, 2'b00);

        @(negedge ACLK);
        ARESET      = 1'b0;
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        #1;
        chk("rel_grant", grant, 2'b00);
        chk("rel_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("rel_s_rready", s_rready, 1'b0);
        s_rvalid   = 1'b0;
        s_rdata    = 32'h0;
        s_rresp    = 2'b00;
        ifu_rready = 1'b0;
        lsu_rready = 1'b0;

        // IFU alone: one cycle of arbitration, then ADDR
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0000;
        #1;
        chk("idle_grant", grant, 2'b00);
        chk("idle_s_arvalid", s_arvalid, 1'b0);
        chk("idle_ifu_arready", ifu_arready, 1'b0);
        @(negedge ACLK);
        serve(1'b0, 32'h8000_0000, 32'h0000_0413, 2'b00, 0);

        // LSU alone, SLVERR response
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h0000_0000;
        @(negedge ACLK);
        serve(1'b1, 32'h0000_0000, 32'h1234_5678, 2'b10, 0);

        // simultaneous requests; last owner is LSU here
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0004;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        #1;
        chk("dual_idle_grant", grant, 2'b00);
        @(negedge ACLK);
        serve(!RR, RR ? 32'h8000_0004 : 32'h8000_1000, 32'hA5A5_0001, 2'b00, 0);
        @(negedge ACLK);
        serve(RR, RR ? 32'h8000_1000 : 32'h8000_0004, 32'hA5A5_0002, 2'b00, 0);

        // repeated dual requests
        for (int k = 0; k < 4; k++) begin
            ifu_arvalid = 1'b1;
            ifu_araddr  = 32'h8000_0010 + 32'(k * 4);
            lsu_arvalid = 1'b1;
            lsu_araddr  = 32'h8000_2000 + 32'(k * 4);
            exp_lsu = RR ? (k % 2 == 1) : 1'b1;
            @(negedge ACLK);
            serve(exp_lsu, exp_lsu ? 32'h8000_2000 + 32'(k * 4) : 32'h8000_0010 + 32'(k * 4),
                  32'h5000_0000 + 32'(k), 2'b00, 0);
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;

        // owner back-pressure on R
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_3000;
        @(negedge ACLK);
        serve(1'b1, 32'h8000_3000, 32'hDEAD_BEEF, 2'b00, 3);

        // reset in DATA with LSU owner, IFU pending
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_4000;
        @(negedge ACLK);
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h8000_0100;
        #1;
        chk("rstm_addr_grant", grant, 2'b10);
        chk("rstm_ifu_arready", ifu_arready, 1'b0);
        @(negedge ACLK);
        lsu_arvalid = 1'b0;
        s_rvalid    = 1'b1;
        s_rdata     = 32'hCAFE_F00D;
        lsu_rready  = 1'b0;
        #1;
        chk("rstm_data_rvalid", lsu_rvalid, 1'b1);
        chk("rstm_data_grant", grant, 2'b10);
        ARESET     = 1'b1;
        lsu_rready = 1'b1;
        #1;
        chk("rstm_grant", grant, 2'b00);
        chk("rstm_lsu_rvalid", lsu_rvalid, 1'b0);
        chk("rstm_lsu_rdata", lsu_rdata, 32'h0);
        chk("rstm_s_rready", s_rready, 1'b0);
        chk("rstm_s_arvalid", s_arvalid, 1'b0);
        chk("rstm_ifu_arready", ifu_arready, 1'b0);
        @(negedge ACLK);
        #1;
        chk("rstm_hold_grant", grant, 2'b00);
        ARESET     = 1'b0;
        s_rvalid   = 1'b0;
        s_rdata    = 32'h0;
        lsu_rready = 1'b0;
        #1;
        chk("rstm_rel_grant", grant, 2'b00);
        chk("rstm_rel_ifu_arready", ifu_arready, 1'b0);
        @(negedge ACLK);
        serve(1'b0, 32'h8000_0100, 32'h0000_55AA, 2'b00, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ysyx_24080014_axi_rd_arbiter.md
Name: ysyx_24080014_axi_rd_arbiter

Overview:
Two-master, one-slave AXI4-Lite read-channel arbiter. It shares the single instruction/data SRAM read port between the IFU and the LSU. The block owns the grant, forwards the AR/R channels of the granted master to the SRAM slave, and isolates the other master until the R handshake completes. Only one transaction is outstanding at a time.

Parameters:
ADDR_W, 32, address width of all AR channels
DATA_W, 32, data width of all R channels

Ports:
ACLK  in  1  clock
ARESET  in  1  reset, asynchronous, active-high
ifu_arvalid  in  1  IFU read-address valid
ifu_araddr  in  ADDR_W  IFU read address
ifu_arready  out  1  IFU read-address accepted
ifu_rvalid  out  1  IFU read-data valid
ifu_rdata  out  DATA_W  IFU read data
ifu_rresp  out  2  IFU read response
ifu_rready  in  1  IFU ready for data
lsu_arvalid / lsu_araddr / lsu_arready / lsu_rvalid / lsu_rdata / lsu_rresp / lsu_rready  same directions and widths as the IFU ports, for the LSU
s_arvalid  out  1  to SRAM: address valid
s_araddr  out  ADDR_W  to SRAM: address
s_arready  in  1  from SRAM: address accepted
s_rvalid  in  1  from SRAM: data valid
s_rdata  in  DATA_W  from SRAM: data
s_rresp  in  2  from SRAM: response
s_rready  out  1  to SRAM: ready for data
grant  out  2  one-hot owner: bit0 IFU, bit1 LSU, 00 idle

Behaviour:
- One clock (ACLK). Reset is asynchronous and active-high (ARESET): state=IDLE, grant=00, last_owner=IFU. All valid/ready outputs are 0 and all data/resp outputs are 0 while ARESET is high and in the first cycle after release.
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any arvalid is high, register the winner into grant and go to ADDR. Otherwise stay in IDLE. No AR is forwarded in IDLE, which gives one cycle of arbitration latency.
- Default arbitration is fixed priority, LSU over IFU. With simultaneous requests, LSU wins.
- ADDR: forward the owner's arvalid to s_arvalid and its araddr to s_araddr. Forward s_arready to the owner's arready only. On s_arvalid && s_arready, go to DATA.
- DATA: s_arvalid=0. Forward s_rvalid, s_rdata and s_rresp to the owner, and the owner's rready to s_rready. On s_rvalid && s_rready, record last_owner, clear grant, and go to IDLE.
- Non-owner outputs (arready, rvalid, rdata, rresp) are 0 at all times. A non-owner's arvalid stays pending and must be held high by that master.
- Owner drops arvalid while in ADDR (protocol violation): s_arvalid follows it. The FSM stays in ADDR; there is no timeout.
- Back-to-back requests: grant→IDLE→grant gives one bubble cycle. Minimum transaction is 3 cycles plus slave latency.
- s_rvalid arriving while in ADDR or IDLE is ignored and not forwarded.
- ARESET asserted mid-transaction: immediate abort to IDLE with all outputs 0. The slave is reset by the same ARESET.
- Combinational paths: s_arready→owner arready, s_rvalid/data→owner, owner rready→s_rready. All are muxed by the registered grant. There is no path from arvalid to any ready output.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration. With simultaneous requests in IDLE, the master that is not last_owner wins. A single requester always wins.
- Undefined: fixed priority LSU > IFU. last_owner is still maintained but does not affect the grant.

Test Plan:
- Reset released, IFU only: ifu_arvalid=1, ifu_araddr=0x80000000, slave returns 0x00000413 with 1-cycle latency → grant=01 the cycle after the request. s_araddr=0x80000000 in ADDR. ifu_rvalid=1 with rdata=0x00000413 and rresp=00. grant=00 after the R handshake.
- Simultaneous requests, IFU 0x80000004 and LSU 0x80001000, fixed priority → LSU served first (s_araddr=0x80001000). IFU served next after one bubble. ifu_arready is never 1 during the LSU transaction.
- Same stimulus with ARB_RR_EN and last_owner=LSU → IFU served first, then LSU. Repeated dual requests alternate grants 01,10,01,10.
- Owner rready=0 for 3 cycles while s_rvalid=1 → s_rready=0 and FSM stays in DATA. Data 0xDEADBEEF is held and delivered on the first rready=1 cycle.
- ARESET pulsed while in DATA with an LSU owner → asynchronous return: grant=00 and all valids/readies 0 during reset. After release, a pending IFU request is granted normally.
- Slave returns rresp=10 (SLVERR) to the LSU at 0x00000000 → lsu_rresp=10, ifu_rresp=00, and the transaction completes normally.
